// File: rtl/occupancy_grid_arbiter_if.sv
// Requester-facing and grid-facing signals of occupancy_grid_arbiter.
// The arbiter uses the slave modport; requesters and the grid sit on the master modport.
//
// Handshake rules:
//   - A request transfers on a clk edge where req_valid[i] & req_ready[i].
//   - A grid command transfers on an edge where grid_input_valid & grid_ready_for_input.
//   - resp_valid is a one-cycle pulse with no back-pressure.
//   - grid_output_valid is a level that the grid holds until its next accept.
interface occupancy_grid_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ*GRID_WIDTH_LOG2-1:0]  req_cell_x;
    logic [NUM_REQ*GRID_HEIGHT_LOG2-1:0] req_cell_y;
    logic [NUM_REQ-1:0]                  req_write_enable;
    logic [NUM_REQ-1:0]                  req_write_occupied;
    logic [NUM_REQ-1:0]                  resp_valid;
    logic                                resp_occupied;
    logic [GRID_WIDTH_LOG2-1:0]          grid_cell_x;
    logic [GRID_HEIGHT_LOG2-1:0]         grid_cell_y;
    logic                                grid_input_valid;
    logic                                grid_write_enable;
    logic                                grid_write_occupied;
    logic                                grid_ready_for_input;
    logic                                grid_output_valid;
    logic                                grid_read_occupied;

    modport slave (
        input  req_valid, req_cell_x, req_cell_y, req_write_enable, req_write_occupied,
        output req_ready, resp_valid, resp_occupied,
        output grid_cell_x, grid_cell_y, grid_input_valid, grid_write_enable, grid_write_occupied,
        input  grid_ready_for_input, grid_output_valid, grid_read_occupied
    );

    modport master (
        output req_valid, req_cell_x, req_cell_y, req_write_enable, req_write_occupied,
        input  req_ready, resp_valid, resp_occupied,
        input  grid_cell_x, grid_cell_y, grid_input_valid, grid_write_enable, grid_write_occupied,
        output grid_ready_for_input, grid_output_valid, grid_read_occupied
    );
endinterface

// File: rtl/occupancy_grid_arbiter.sv
// Round-robin arbiter sharing one occupancy_grid between NUM_REQ requesters.
// It keeps a single transaction outstanding and routes the completion back to the owning requester.
module occupancy_grid_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    occupancy_grid_arbiter_if.slave  bus,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic [1:0]               state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } state_t;

    state_t                      state;
    logic [ID_W-1:0]             rr_ptr;
    logic [ID_W-1:0]             winner;
    logic                        winner_found;
    int                          scan_idx;
    logic [NUM_REQ-1:0]          ready_c;
    logic                        accept;
    logic [GRID_WIDTH_LOG2-1:0]  sel_x;
    logic [GRID_HEIGHT_LOG2-1:0] sel_y;

    // Scan starts just after the last winner, so the previous owner has the lowest priority.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        scan_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!winner_found && bus.req_valid[scan_idx]) begin
                winner_found = 1'b1;
                winner       = ID_W'(scan_idx);
            end
        end
    end

    assign accept = (state == IDLE) && winner_found && !rst;

    always_comb begin
        ready_c = '0;
        if (accept) ready_c[winner] = 1'b1;
    end

    assign bus.req_ready = ready_c;
    assign sel_x = bus.req_cell_x[int'(winner)*GRID_WIDTH_LOG2 +: GRID_WIDTH_LOG2];
    assign sel_y = bus.req_cell_y[int'(winner)*GRID_HEIGHT_LOG2 +: GRID_HEIGHT_LOG2];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            rr_ptr                  <= ID_W'(NUM_REQ - 1);
            grant_id                <= '0;
            bus.grid_cell_x         <= '0;
            bus.grid_cell_y         <= '0;
            bus.grid_input_valid    <= 1'b0;
            bus.grid_write_enable   <= 1'b0;
            bus.grid_write_occupied <= 1'b0;
            bus.resp_valid          <= '0;
            bus.resp_occupied       <= 1'b0;
        end else begin
            bus.resp_valid    <= '0;
            bus.resp_occupied <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.grid_cell_x         <= sel_x;
                        bus.grid_cell_y         <= sel_y;
                        bus.grid_write_enable   <= bus.req_write_enable[winner];
                        bus.grid_write_occupied <= bus.req_write_occupied[winner];
                        bus.grid_input_valid    <= 1'b1;
                        grant_id                <= winner;
                        rr_ptr                  <= winner;
                        state                   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.grid_ready_for_input) begin
                        bus.grid_input_valid <= 1'b0;
                        state <= bus.grid_write_enable ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (bus.grid_output_valid) begin
                        bus.resp_valid[grant_id] <= 1'b1;
                        bus.resp_occupied        <= bus.grid_read_occupied;
                        state                    <= IDLE;
                    end
                end
                WAIT_WR: begin
                    // The grid has no write completion; returning ready means write-back is done.
                    if (bus.grid_ready_for_input) begin
                        bus.resp_valid[grant_id] <= 1'b1;
                        state                    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/occupancy_grid_arbiter.md
Name: occupancy_grid_arbiter

Overview:
- Shares one occupancy_grid instance between NUM_REQ requesters, e.g. collision checkers plus a map loader.
- Uses round-robin arbitration and keeps one transaction outstanding at the grid.
- Tracks which requester owns the outstanding transaction.
- Returns a one-hot completion to that requester: read data for reads, an acknowledge for writes.

Parameters:
- NUM_REQ, 4, number of requester ports (≥2); ID_W = $clog2(NUM_REQ) is derived internally.
- GRID_WIDTH_LOG2, 8, cell_x width; matches the grid instance.
- GRID_HEIGHT_LOG2, 8, cell_y width; matches the grid instance.

Ports:
- clk  in  1  single clock; the memory clock of the grid.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; a request transfers when valid&ready.
- req_cell_x  in  NUM_REQ×GRID_WIDTH_LOG2  packed per-requester cell x.
- req_cell_y  in  NUM_REQ×GRID_HEIGHT_LOG2  packed per-requester cell y.
- req_write_enable  in  NUM_REQ  1=write, 0=read.
- req_write_occupied  in  NUM_REQ  value to write.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_occupied  out  1  read result, qualified by resp_valid; 0 on write acks.
- grid_cell_x  out  GRID_WIDTH_LOG2  to grid cell_x.
- grid_cell_y  out  GRID_HEIGHT_LOG2  to grid cell_y.
- grid_input_valid  out  1  to grid input_valid.
- grid_write_enable  out  1  to grid write_enable.
- grid_write_occupied  out  1  to grid write_occupied.
- grid_ready_for_input  in  1  from grid ready_for_input.
- grid_output_valid  in  1  from grid output_valid; level, held until the grid's next accept.
- grid_read_occupied  in  1  from grid read_occupied.
- busy  out  1  state≠IDLE.
- grant_id  out  ID_W  owner of the current or last transaction.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0.
  - All grid_* outputs 0; resp_valid=0, resp_occupied=0.
  - req_ready is gated to 0 while rst=1.
  - Any in-flight transaction is dropped with no response; the grid is reset by the same system reset.
- Arbitration (combinational, IDLE only):
  - Winner = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - req_ready[winner]=1 only in IDLE; all other bits are 0.
- IDLE:
  - On an accept, latch cell_x/y, write_enable and write_occupied of the winner into grid_* registers; grant_id←winner; rr_ptr←winner.
  - Next state ISSUE, with grid_input_valid=1 from the next cycle.
- ISSUE:
  - Hold grid_input_valid=1 and payload stable until a cycle with grid_ready_for_input=1 (that is the grid's transfer).
  - Then grid_input_valid←0 and go to WAIT_WR if write, else WAIT_RD.
- WAIT_RD:
  - The first cycle with grid_output_valid=1 is the result.
  - Register resp_valid[grant_id]=1 and resp_occupied=grid_read_occupied for one cycle; go to IDLE.
- WAIT_WR:
  - The grid gives no write completion, so the first cycle with grid_ready_for_input=1 marks write-back done.
  - Register resp_valid[grant_id]=1 and resp_occupied=0 for one cycle; go to IDLE.
- Stale levels: grid_output_valid and grid_ready_for_input are sampled only in WAIT_RD, ISSUE and WAIT_WR. On entry to WAIT_RD/WAIT_WR both are already low, because the grid clears them on its accept edge.
- Latency, with an idle occupancy_grid attached and request accepted in cycle T:
  - grid_input_valid is high in T+1.
  - Read: resp_valid is high in T+5.
  - Write: resp_valid is high in T+6.
  - Back-to-back throughput is therefore one read per 5 cycles and one write per 6 cycles.
- Simultaneous events:
  - The response pulse cycle is an IDLE cycle, so resp_valid and a new req_ready may be high together, including for the same requester.
  - A requester whose resp_valid is high may be granted again in that same cycle.
- Requester obligations: payload is held stable while req_valid=1 and req_ready=0. Deasserting valid before ready is permitted and cancels the request.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… No requester waits more than NUM_REQ-1 other transactions.
- No timeout: a grid that never responds leaves the arbiter in WAIT_RD or WAIT_WR until reset.

Test Plan:
- Single read: after reset, req_valid[2]=1, cell (5,9), grid bit set → req_ready[2] high in T, grid_input_valid high T+1 with cell (5,9), resp_valid=4'b0100 with resp_occupied=1 in T+5.
- Write then read: requester 1 writes occupied=1 to cell (200,3), then reads it → write resp_valid[1] at T+6 with resp_occupied=0; read returns resp_occupied=1; neighbouring cell (201,3) reads 0.
- Round-robin: all four req_valid held high → grant order 0,1,2,3,0; each resp_valid targets the matching requester; rr_ptr wraps 3→0.
- Stalled grid: model holds grid_ready_for_input=0 for 7 cycles in ISSUE → grid_input_valid and payload stay stable; transfer occurs on the first ready cycle; no req_ready is asserted meanwhile.
- Reset mid-read: assert rst in WAIT_RD → busy, resp_valid, grid_input_valid and req_ready are 0 immediately (async) and no response is emitted; after release, requester 0 is granted first.
- Same-cycle response and grant: requester 3 re-requests while its read completes → resp_valid[3] and req_ready[3] are both high in that cycle; if others are valid, requester 0 wins instead.
